// File: rtl/audio_dac_transmitter.sv
// rtl/audio_dac_transmitter.sv - left-justified stereo PCM serialiser onto the codec DAC line
module audio_dac_transmitter #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DAC_LRCK,
  output logic                  AUD_DAC_DATA,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Codec clock synchronisers and edge detection
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic                   bclk_prev_q;
  logic                   lrck_prev_q;
  logic [SYNC_STAGES:0]   sync_vld_q;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   edge_ok;
  logic                   bclk_fall;
  logic                   lrck_rise;
  logic                   lrck_fall;

  // Holding register
  logic [DATA_WIDTH-1:0]  hold_left_q;
  logic [DATA_WIDTH-1:0]  hold_right_q;
  logic                   hold_full_q;
  logic                   hold_full_d;
  logic                   ready_en_q;
  logic                   accept;

  // Active frame state
  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  right_word_q;
  logic [DATA_WIDTH-1:0]  sh_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   underrun_q;
  logic [DATA_WIDTH-1:0]  left_d;
  logic [DATA_WIDTH-1:0]  right_d;

  // Shift both codec clocks through the synchroniser chain, then one edge-detect flop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      sync_vld_q  <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_DAC_LRCK};
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
      lrck_prev_q <= lrck_sync_q[SYNC_STAGES-1];
      sync_vld_q  <= {sync_vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];

  // Edges are only trusted once the chain and the edge flop hold real pin samples,
  // so a reset released while LRCK is high does not fake a frame start.
  assign edge_ok   = sync_vld_q[SYNC_STAGES];
  assign bclk_fall = edge_ok &  bclk_prev_q & ~bclk_s;
  assign lrck_rise = edge_ok & ~lrck_prev_q &  lrck_s;
  assign lrck_fall = edge_ok &  lrck_prev_q & ~lrck_s;

  // Ready stays low during reset and follows the hold flag afterwards
  assign sample_ready = ready_en_q & ~hold_full_q;
  assign accept       = sample_valid & sample_ready;

  // Words for the next frame (zeros on underrun) and the hold flag update
  always_comb begin
    left_d      = '0;
    right_d     = '0;
    hold_full_d = hold_full_q;
    if (hold_full_q) begin
      left_d  = hold_left_q;
      right_d = hold_right_q;
    end
    // A transfer and an accept cannot coincide: accept needs an empty hold.
    if (lrck_rise && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end
  end

  // Holding register capture; a reset discards any pending pair
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_left_q  <= '0;
      hold_right_q <= '0;
      hold_full_q  <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      hold_full_q <= hold_full_d;
      if (accept) begin
        hold_left_q  <= sample_left;
        hold_right_q <= sample_right;
      end
    end
  end

  // Frame sequencer: LRCK edges load a word MSB first, BCLK falls shift it out
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      right_word_q <= '0;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      underrun_q   <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (lrck_rise) begin
        // Frame start from any state; the left word goes straight into the shifter.
        state_q      <= ST_LEFT;
        right_word_q <= right_d;
        sh_q         <= left_d;
        bit_cnt_q    <= CNT_ONE;
        underrun_q   <= ~hold_full_q;
      end else if (lrck_fall && (state_q != ST_IDLE)) begin
        // Covers the normal left-to-right switch and a repeated fall while in RIGHT.
        state_q   <= ST_RIGHT;
        sh_q      <= right_word_q;
        bit_cnt_q <= CNT_ONE;
      end else if (bclk_fall && (state_q != ST_IDLE)) begin
        if (bit_cnt_q < CNT_FULL) begin
          sh_q      <= {sh_q[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + CNT_ONE;
        end else begin
          sh_q <= '0;
        end
      end
    end
  end

  // The serial line is the shifter MSB, a flop output that is zero in IDLE and reset
  assign AUD_DAC_DATA = sh_q[DATA_WIDTH-1];
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_dac_transmitter.sv
// tb/tb_audio_dac_transmitter.sv - self-checking bench for audio_dac_transmitter
module tb_audio_dac_transmitter;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DAC_LRCK = 1'b0;
  logic          AUD_DAC_DATA;
  logic [DW-1:0] sample_left = '0;
  logic [DW-1:0] sample_right = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          underrun;

  int n_checks = 0;
  int n_fail = 0;
  int ur_cnt = 0;
  int rdy_drop = 0;
  bit mon_ready = 1'b0;
  logic [31:0] exp_q[$];

  audio_dac_transmitter #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .AUD_BCLK(AUD_BCLK),
    .AUD_DAC_LRCK(AUD_DAC_LRCK),
    .AUD_DAC_DATA(AUD_DAC_DATA),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (underrun === 1'b1) ur_cnt++;
    if (mon_ready && (sample_ready !== 1'b1)) rdy_drop++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected bit stream of one channel: n BCLK periods, word MSB first, zeros beyond DW.
  function automatic logic [31:0] model_bits(input logic [DW-1:0] w, input int n);
    logic [31:0] v;
    logic b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (i < DW) b = w[DW-1-i];
      else b = 1'b0;
      v = {v[30:0], b};
    end
    return v;
  endfunction

  task automatic align(input int ph);
    @(posedge CLK);
    #(ph);
  endtask

  // Codec model: one stereo frame, LRCK changes with BCLK fall, DATA sampled at BCLK rise.
  task automatic run_frame(input int n, input int h, input int rst_bit,
                           output logic [31:0] cl, output logic [31:0] cr);
    logic [31:0] v;
    cl = '0;
    cr = '0;
    for (int ch = 0; ch < 2; ch++) begin
      v = '0;
      for (int i = 0; i < n; i++) begin
        AUD_BCLK = 1'b0;
        if (i == 0) AUD_DAC_LRCK = (ch == 0);
        #(h * 10);
        v = {v[30:0], AUD_DAC_DATA};
        AUD_BCLK = 1'b1;
        if ((ch == 0) && (i == rst_bit)) begin
          RESET = 1'b1;
          #1;
          n_checks++;
          if (AUD_DAC_DATA !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data_async: got %b want 0", AUD_DAC_DATA);
          end
          n_checks++;
          if (sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", sample_ready);
          end
          #(h * 10 - 1);
          RESET = 1'b0;
        end else begin
          #(h * 10);
        end
      end
      if (ch == 0) cl = v;
      else cr = v;
    end
  endtask

  // Producer: present a pair and wait (bounded) until it is accepted; valid is left high.
  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit acc;
    acc = 1'b0;
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    for (int k = 0; (k < 5000) && !acc; k++) begin
      @(negedge CLK);
      acc = (sample_ready === 1'b1);
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL push_accept: got no accept want accept of %h/%h", l, r);
    end else begin
      exp_q.push_back({l, r});
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (AUD_DAC_DATA !== 1'b0) begin n_fail++; $display("FAIL rst_data: got %b want 0", AUD_DAC_DATA); end
    n_checks++;
    if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", sample_ready); end
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    n_checks++;
    if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", sample_ready); end
    n_checks++;
    if (AUD_DAC_DATA !== 1'b0) begin n_fail++; $display("FAIL post_rst_data: got %b want 0", AUD_DAC_DATA); end
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL post_rst_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_first_frame();
    logic [31:0] cl, cr;
    int u0;
    push_pair(16'hA5C3, 16'h3C5A);
    sample_valid = 1'b0;
    u0 = ur_cnt;
    align(3);
    run_frame(16, 4, -1, cl, cr);
    n_checks++;
    if (cl !== model_bits(16'hA5C3, 16)) begin n_fail++; $display("FAIL first_left: got %h want %h", cl, model_bits(16'hA5C3, 16)); end
    n_checks++;
    if (cr !== model_bits(16'h3C5A, 16)) begin n_fail++; $display("FAIL first_right: got %h want %h", cr, model_bits(16'h3C5A, 16)); end
    n_checks++;
    if (ur_cnt - u0 != 0) begin n_fail++; $display("FAIL first_underrun: got %0d want 0", ur_cnt - u0); end
  endtask

  task automatic test_underrun();
    logic [31:0] cl, cr;
    int u0;
    u0 = ur_cnt;
    rdy_drop = 0;
    mon_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(16, 5, -1, cl, cr);
      n_checks++;
      if ((cl !== 32'h0) || (cr !== 32'h0)) begin n_fail++; $display("FAIL underrun_zeros: got %h/%h want 0/0", cl, cr); end
    end
    mon_ready = 1'b0;
    n_checks++;
    if (ur_cnt - u0 != 2) begin n_fail++; $display("FAIL underrun_pulses: got %0d want 2", ur_cnt - u0); end
    n_checks++;
    if (rdy_drop != 0) begin n_fail++; $display("FAIL underrun_ready_held: got %0d low cycles want 0", rdy_drop); end
  endtask

  task automatic test_valid_at_rise();
    logic [31:0] cl, cr;
    logic [DW-1:0] r3;
    int u0;
    r3 = DW'($urandom);
    exp_q.delete();
    u0 = ur_cnt;
    align(3);
    fork
      run_frame(16, 4, -1, cl, cr);
      begin
        repeat (2) @(posedge CLK);
        #1;
        sample_left  = 16'h8001;
        sample_right = r3;
        sample_valid = 1'b1;
        @(posedge CLK);
        #1;
        sample_valid = 1'b0;
        n_checks++;
        if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL rise_accept: got ready %b want 0", sample_ready); end
      end
    join
    n_checks++;
    if ((cl !== 32'h0) || (cr !== 32'h0)) begin n_fail++; $display("FAIL rise_zeros: got %h/%h want 0/0", cl, cr); end
    n_checks++;
    if (ur_cnt - u0 != 1) begin n_fail++; $display("FAIL rise_underrun: got %0d want 1", ur_cnt - u0); end
    n_checks++;
    if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL rise_ready_between: got %b want 0", sample_ready); end
    u0 = ur_cnt;
    run_frame(16, 4, -1, cl, cr);
    n_checks++;
    if (cl !== model_bits(16'h8001, 16)) begin n_fail++; $display("FAIL rise_next_left: got %h want %h", cl, model_bits(16'h8001, 16)); end
    n_checks++;
    if (cr !== model_bits(r3, 16)) begin n_fail++; $display("FAIL rise_next_right: got %h want %h", cr, model_bits(r3, 16)); end
    n_checks++;
    if (ur_cnt - u0 != 0) begin n_fail++; $display("FAIL rise_next_underrun: got %0d want 0", ur_cnt - u0); end
    n_checks++;
    if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL rise_ready_after: got %b want 1", sample_ready); end
  endtask

  task automatic test_long_channel();
    logic [31:0] cl, cr;
    int u0;
    push_pair(16'hFFFF, 16'hFFFF);
    sample_valid = 1'b0;
    u0 = ur_cnt;
    run_frame(32, 4, -1, cl, cr);
    n_checks++;
    if (cl !== model_bits(16'hFFFF, 32)) begin n_fail++; $display("FAIL long_left: got %h want %h", cl, model_bits(16'hFFFF, 32)); end
    n_checks++;
    if (cr !== model_bits(16'hFFFF, 32)) begin n_fail++; $display("FAIL long_right: got %h want %h", cr, model_bits(16'hFFFF, 32)); end
    n_checks++;
    if (ur_cnt - u0 != 0) begin n_fail++; $display("FAIL long_underrun: got %0d want 0", ur_cnt - u0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] cl, cr;
    logic [DW-1:0] cl_w, cr_w;
    int u0;
    push_pair(16'hFFFF, 16'hFFFF);
    sample_valid = 1'b0;
    u0 = ur_cnt;
    fork
      run_frame(16, 4, 7, cl, cr);
      begin
        repeat (10) @(posedge CLK);
        #1;
        push_pair(16'h1234, 16'h5678);
        sample_valid = 1'b0;
      end
    join
    n_checks++;
    if (cl !== 32'h0000FF00) begin n_fail++; $display("FAIL rstmid_left: got %h want 0000ff00", cl); end
    n_checks++;
    if (cr !== 32'h0) begin n_fail++; $display("FAIL rstmid_right: got %h want 0", cr); end
    n_checks++;
    if (ur_cnt - u0 != 0) begin n_fail++; $display("FAIL rstmid_underrun: got %0d want 0", ur_cnt - u0); end
    n_checks++;
    if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", sample_ready); end
    u0 = ur_cnt;
    run_frame(16, 4, -1, cl, cr);
    n_checks++;
    if ((cl !== 32'h0) || (cr !== 32'h0)) begin n_fail++; $display("FAIL rstmid_discard: got %h/%h want 0/0", cl, cr); end
    n_checks++;
    if (ur_cnt - u0 != 1) begin n_fail++; $display("FAIL rstmid_discard_underrun: got %0d want 1", ur_cnt - u0); end
    cl_w = DW'($urandom);
    cr_w = DW'($urandom);
    push_pair(cl_w, cr_w);
    sample_valid = 1'b0;
    run_frame(16, 4, -1, cl, cr);
    n_checks++;
    if ((cl !== model_bits(cl_w, 16)) || (cr !== model_bits(cr_w, 16))) begin
      n_fail++;
      $display("FAIL rstmid_resume: got %h/%h want %h/%h", cl, cr, model_bits(cl_w, 16), model_bits(cr_w, 16));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_l[8];
    logic [31:0] got_r[8];
    int got_n[8];
    logic [31:0] e;
    int u0;
    exp_q.delete();
    u0 = ur_cnt;
    align($urandom_range(1, 9));
    fork
      begin
        for (int k = 0; k < 8; k++) push_pair(DW'($urandom), DW'($urandom));
        sample_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 8; f++) begin
          got_n[f] = $urandom_range(16, 24);
          run_frame(got_n[f], $urandom_range(4, 16), -1, got_l[f], got_r[f]);
        end
      end
    join
    n_checks++;
    if (exp_q.size() != 8) begin n_fail++; $display("FAIL b2b_accepted: got %0d want 8", exp_q.size()); end
    for (int f = 0; f < 8; f++) begin
      e = (f < exp_q.size()) ? exp_q[f] : 32'h0;
      n_checks++;
      if ((got_l[f] !== model_bits(e[31:16], got_n[f])) || (got_r[f] !== model_bits(e[15:0], got_n[f]))) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got %h/%h want %h/%h", f, got_l[f], got_r[f],
                 model_bits(e[31:16], got_n[f]), model_bits(e[15:0], got_n[f]));
      end
    end
    n_checks++;
    if (ur_cnt - u0 != 0) begin n_fail++; $display("FAIL b2b_underrun: got %0d want 0", ur_cnt - u0); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_valid_at_rise();
    test_long_channel();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
